vga_plot_arbiter: RTL

Shares the single VGA adapter write port (x, y, colour, plot) among `N_REQ` pixel producers: the full-screen background plotter, the word/sprite plotter and the erase plotter. It grants one requester at a time using round-robin order and holds the grant until that requester signals `done`. It registers the muxed pixel bus toward the adapter and suppresses off-screen writes. It sits between the plotting engines and the VGA adapter in the display path.

---
 rtl/vga_plot_arbiter_pkg.sv | 17 +
 rtl/vga_plot_arbiter_rr_picker.sv | 23 ++
 rtl/vga_plot_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/vga_plot_arbiter_pkg.sv
// Shared constants and types for the VGA plot arbiter.
package plot_pkg;

    localparam int X_W      = 9;
    localparam int Y_W      = 8;
    localparam int COLOUR_W = 6;

    localparam logic [X_W-1:0] SCREEN_W = 9'd320;
    localparam logic [Y_W-1:0] SCREEN_H = 8'd240;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/vga_plot_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request bit at or after ptr,
// wrapping modulo N_REQ, returned one-hot together with a valid flag.
module rr_picker #(
    parameter int N_REQ = 3,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] pick,
    output logic             valid
);

    logic [N_REQ-1:0] w_rot;
    logic [N_REQ-1:0] w_low;

    // Rotate so ptr lands on bit 0, isolate the lowest set bit with the
    // two's-complement trick, then rotate the one-hot back into place.
    assign w_rot = N_REQ'({req, req} >> ptr);
    assign w_low = w_rot & (~w_rot + 1'b1);
    assign pick  = N_REQ'(({w_low, w_low} << ptr) >> N_REQ);
    assign valid = |req;

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing the VGA adapter write port among N_REQ plotters.
// Registers the granted pixel bus and drops off-screen writes.
// Optional grant watchdog: define PLOT_ARB_WATCHDOG_EN.
module vga_plot_arbiter
    import plot_pkg::*;
#(
    parameter int N_REQ   = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          done,
    input  logic [N_REQ*X_W-1:0]      req_x,
    input  logic [N_REQ*Y_W-1:0]      req_y,
    input  logic [N_REQ*COLOUR_W-1:0] req_colour,
    input  logic [N_REQ-1:0]          req_plot,
    output logic [N_REQ-1:0]          grant,
    output logic [X_W-1:0]            vga_x,
    output logic [Y_W-1:0]            vga_y,
    output logic [COLOUR_W-1:0]       vga_colour,
    output logic                      vga_plot,
    output logic                      busy,
    output logic                      timeout
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || TIMEOUT < 1) begin : g_bad_params
        $error("vga_plot_arbiter: N_REQ must be >= 2 and TIMEOUT >= 1");
    end

    arb_state_t          r_state, w_next;
    logic [PW-1:0]       r_ptr;
    logic [PW-1:0]       r_gidx;
    logic [N_REQ-1:0]    r_grant;
    logic [X_W-1:0]      r_x;
    logic [Y_W-1:0]      r_y;
    logic [COLOUR_W-1:0] r_colour;
    logic                r_plot;
    logic                r_busy;
    logic                r_timeout;

    logic [N_REQ-1:0]    w_pick;
    logic                w_pick_valid;
    logic [PW-1:0]       w_pick_idx;
    logic [X_W-1:0]      w_gx;
    logic [Y_W-1:0]      w_gy;
    logic [COLOUR_W-1:0] w_gcolour;
    logic                w_gplot, w_gdone, w_greq;
    logic                w_release, w_fire_to, w_wd_hit;

    rr_picker #(.N_REQ(N_REQ), .PW(PW)) u_picker (
        .req   (req),
        .ptr   (r_ptr),
        .pick  (w_pick),
        .valid (w_pick_valid)
    );

    // One-hot pick to index, kept alongside grant to drive the bus mux.
    always_comb begin
        w_pick_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_pick[i]) w_pick_idx = PW'(i);
        end
    end

    assign w_gx      = req_x[r_gidx*X_W +: X_W];
    assign w_gy      = req_y[r_gidx*Y_W +: Y_W];
    assign w_gcolour = req_colour[r_gidx*COLOUR_W +: COLOUR_W];
    assign w_gplot   = req_plot[r_gidx];
    assign w_gdone   = done[r_gidx];
    assign w_greq    = req[r_gidx];

`ifdef PLOT_ARB_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_wd_cnt;

    // Idle-grant counter: cleared by any granted activity or outside GRANT.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                                     r_wd_cnt <= '0;
        else if (r_state != GRANT || w_gplot || w_gdone) r_wd_cnt <= '0;
        else                                             r_wd_cnt <= r_wd_cnt + 1'b1;
    end

    assign w_wd_hit = (r_state == GRANT) && !w_gplot && !w_gdone
                      && (r_wd_cnt == CW'(TIMEOUT - 1));
`else
    assign w_wd_hit = 1'b0;
`endif

    // Next-state logic; a normal release takes priority over the watchdog.
    always_comb begin
        w_next    = r_state;
        w_release = 1'b0;
        w_fire_to = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_pick_valid) w_next = GRANT;
            end
            GRANT: begin
                if (w_gdone || !w_greq) begin
                    w_next    = RELEASE;
                    w_release = 1'b1;
                end else if (w_wd_hit) begin
                    w_next    = RELEASE;
                    w_release = 1'b1;
                    w_fire_to = 1'b1;
                end
            end
            RELEASE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State, grant, pointer and registered pixel bus.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_gidx    <= '0;
            r_grant   <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_colour  <= '0;
            r_plot    <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_busy    <= (w_next == GRANT);
            r_timeout <= w_fire_to;
            if (r_state == IDLE && w_pick_valid) begin
                r_grant <= w_pick;
                r_gidx  <= w_pick_idx;
            end
            if (w_release) begin
                r_grant <= '0;
                r_ptr   <= (r_gidx == PW'(N_REQ - 1)) ? '0 : r_gidx + 1'b1;
            end
            if (r_state == GRANT) begin
                r_x      <= w_gx;
                r_y      <= w_gy;
                r_colour <= w_gcolour;
                r_plot   <= w_gplot && (w_gx < SCREEN_W) && (w_gy < SCREEN_H);
            end else begin
                r_plot   <= 1'b0;
            end
        end
    end

    assign grant      = r_grant;
    assign vga_x      = r_x;
    assign vga_y      = r_y;
    assign vga_colour = r_colour;
    assign vga_plot   = r_plot;
    assign busy       = r_busy;
    assign timeout    = r_timeout;

endmodule
